chdr_pkt_checker: RTL and testbench
===================================

Name: chdr_pkt_checker

Overview:
Stream-sink stage that consumes the CHDR packet stream produced by a file-source block, whether on the loopback path or on the str_sink side of a null/verify NoC block. It parses each header and validates the 12-bit sequence number, the 16-bit byte-length field against the actual beat count, and optionally the SID. Per-packet statistics and error counters are exposed as ports for the host readback mux. The block is configured over the standard settings bus.

Parameters:
SR_CTRL, 0, settings address of the control register (bit0 enable, bit1 sid_check_en)
SR_EXPECT_SID, 1, settings address of the 32-bit expected SID
SR_CLEAR, 2, settings address; any write clears counters and the sequence-tracking state

Ports:
clk  in  1  single clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
set_stb  in  1  settings write strobe
set_addr  in  8  settings address
set_data  in  32  settings data
i_tdata  in  64  CHDR beats
i_tlast  in  1  last beat of packet
i_tvalid  in  1  beat valid
i_tready  out  1  ready
pkt_count  out  32  packets fully received since clear
seq_err_count  out  32  sequence discontinuities
len_err_count  out  32  length-field/beat-count mismatches
sid_err_count  out  32  SID mismatches (only when sid_check_en=1)
last_seqnum  out  12  seqnum of most recent header
last_len  out  16  length field of most recent header

Behaviour:
- Reset values: all counters 0; last_seqnum=0; last_len=0; enable=0; sid_check_en=0; expected SID=0; first_pkt=1; state=S_HEAD; i_tready=0 during the reset cycle and 1 thereafter.
- i_tready stays 1 in every state. The block never back-pressures. When enable=0, beats are accepted and discarded, the FSM is held in S_HEAD, and counters are frozen.
- Settings take effect the cycle after set_stb. A write to SR_CLEAR on the same cycle as a counter update: the clear wins and all counters read 0. A clear does not change the FSM state.
- Header decode (beat in S_HEAD): has_time=tdata[61], seq=tdata[59:48], len=tdata[47:32], sid=tdata[31:0].
- Header beat effects: latch last_seqnum and last_len. Compute exp_beats=(len+7)>>3 as a 14-bit value and set beat_cnt=1.
- Seq check: if first_pkt=0 and seq != (prev_seq+1) mod 4096, increment seq_err_count. Then set prev_seq=seq and first_pkt=0. Wrap from 4095 to 0 is legal.
- SID check: if sid_check_en=1 and sid != expected SID, increment sid_err_count.
- len<8, or len<16 with has_time=1, counts as a length error immediately. The remaining beats of that packet are consumed in S_DRAIN.
- FSM states:
  - S_HEAD: if tlast on the header beat, finish the packet (length OK only if exp_beats==1); otherwise go to S_BODY.
  - S_BODY: each beat increments beat_cnt.
    - tlast with beat_cnt+1==exp_beats: packet OK.
    - tlast with beat_cnt+1<exp_beats: length error, go to S_HEAD.
    - beat_cnt+1==exp_beats without tlast: length error, go to S_DRAIN.
  - S_DRAIN: discard beats until tlast, then go to S_HEAD.
- Every packet ends on its tlast. pkt_count increments on that beat whether or not the packet had errors. At most one len error is counted per packet.
- All counters saturate at 0xFFFF_FFFF and do not wrap.
- Counter updates are visible on the ports one cycle after the causing beat.
- Reset mid-packet returns the FSM to S_HEAD. The next beat is treated as a header.

Test Plan:
- Enable, send 4 packets: seq 0..3, len=24, 3 beats each, no time -> pkt_count=4, all error counters 0, last_seqnum=3, last_len=24.
- Send seq 4094, 4095, 0, 2 -> seq_err_count=1 (the 0→2 gap only; the 4095→0 wrap is legal).
- Header len=32 but tlast on beat 2 -> len_err=1. Header len=16 with 5 beats -> len_err=2, S_DRAIN swallows beats 3-5, and the next header parses correctly.
- sid_check_en=1, expected SID 0x0001_0002; send SIDs 0x0001_0002 and 0x0003_0004 -> sid_err_count=1. With sid_check_en=0, the same traffic leaves sid_err_count unchanged.
- Write SR_CLEAR on the same cycle as a packet's tlast -> all counters 0 next cycle; the next packet, with any seq, produces no seq error.
- enable=0 while 3 packets stream -> i_tready=1 throughout and counters unchanged. Assert reset mid-body, release, send a fresh packet -> pkt_count=1, no len error.

Source files
------------

// File: rtl/chdr_pkt_checker.sv
// ---------------------------------------------------------------------------
// chdr_pkt_checker
//
// Purpose: sink for a CHDR packet stream. It parses each header and checks
// three things: the 12-bit sequence number is contiguous, the 16-bit
// byte-length field agrees with the number of beats received, and
// (optionally) the SID matches an expected value. Packet and error counters
// are exposed for host readback. The block never back-pressures.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   set_stb/addr/data   settings bus (control, expected SID, clear)
//   i_tdata/tlast/
//   i_tvalid/i_tready   CHDR input stream; i_tready is low only in reset
//   pkt_count           packets ended (on tlast) since clear
//   seq_err_count       sequence-number discontinuities
//   len_err_count       length field vs. beat count mismatches (<=1/packet)
//   sid_err_count       SID mismatches while SID checking is enabled
//   last_seqnum/len     header fields of the most recent header
//
// state   | meaning
// --------+----------------------------------------------------------
// S_HEAD  | next accepted beat is a header
// S_BODY  | counting payload beats against the header's length
// S_DRAIN | length error already counted; discard beats until tlast
// ---------------------------------------------------------------------------
module chdr_pkt_checker #(
   parameter logic [7:0] SR_CTRL       = 8'd0,
   parameter logic [7:0] SR_EXPECT_SID = 8'd1,
   parameter logic [7:0] SR_CLEAR      = 8'd2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        set_stb,
   input  logic [7:0]  set_addr,
   input  logic [31:0] set_data,
   input  logic [63:0] i_tdata,
   input  logic        i_tlast,
   input  logic        i_tvalid,
   output logic        i_tready,
   output logic [31:0] pkt_count,
   output logic [31:0] seq_err_count,
   output logic [31:0] len_err_count,
   output logic [31:0] sid_err_count,
   output logic [11:0] last_seqnum,
   output logic [15:0] last_len
);

   typedef enum logic [1:0] {
      S_HEAD  = 2'd0,
      S_BODY  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t      state, state_next;
   logic        enable, sid_check_en;
   logic [31:0] expect_sid;
   logic        first_pkt;
   logic [11:0] prev_seq;
   logic [13:0] beat_cnt, beat_cnt_next, beat_inc;
   logic [13:0] exp_beats, exp_beats_next;

   logic        clear_stb;
   logic        beat;
   logic        hdr_has_time;
   logic [11:0] hdr_seq;
   logic [15:0] hdr_len;
   logic [31:0] hdr_sid;
   logic [16:0] len_plus;
   logic [13:0] hdr_exp;
   logic        hdr_short;
   logic        hdr_seen, pkt_done, len_err, seq_err, sid_err;
   logic        unused_bits;

   // Ready is simply "not in reset", so the stream is never stalled.
   assign i_tready  = ~reset;
   assign beat      = i_tvalid & i_tready & enable;
   assign clear_stb = set_stb && (set_addr == SR_CLEAR);

   assign hdr_has_time = i_tdata[61];
   assign hdr_seq      = i_tdata[59:48];
   assign hdr_len      = i_tdata[47:32];
   assign hdr_sid      = i_tdata[31:0];
   // Ceiling of len/8 in 14 bits; the extra top bit keeps len=65535 exact.
   assign len_plus     = {1'b0, hdr_len} + 17'd7;
   assign hdr_exp      = len_plus[16:3];
   assign hdr_short    = (hdr_len < 16'd8) || (hdr_has_time && (hdr_len < 16'd16));
   assign beat_inc     = beat_cnt + 14'd1;
   assign unused_bits  = ^{i_tdata[63:62], i_tdata[60], len_plus[2:0]};

   assign seq_err = hdr_seen && !first_pkt && (hdr_seq != prev_seq + 12'd1);
   assign sid_err = hdr_seen && sid_check_en && (hdr_sid != expect_sid);

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         enable       <= 1'b0;
         sid_check_en <= 1'b0;
         expect_sid   <= 32'd0;
      end else if (set_stb) begin
         if (set_addr == SR_CTRL) begin
            enable       <= set_data[0];
            sid_check_en <= set_data[1];
         end
         if (set_addr == SR_EXPECT_SID)
            expect_sid <= set_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= S_HEAD;
         beat_cnt  <= 14'd0;
         exp_beats <= 14'd0;
      end else begin
         state     <= state_next;
         beat_cnt  <= beat_cnt_next;
         exp_beats <= exp_beats_next;
      end
   end

   always_comb begin
      state_next     = state;
      beat_cnt_next  = beat_cnt;
      exp_beats_next = exp_beats;
      hdr_seen       = 1'b0;
      pkt_done       = 1'b0;
      len_err        = 1'b0;
      if (!enable) begin
         state_next = S_HEAD;
      end else if (beat) begin
         case (state)
            S_HEAD: begin
               hdr_seen       = 1'b1;
               exp_beats_next = hdr_exp;
               beat_cnt_next  = 14'd1;
               if (hdr_short) begin
                  len_err = 1'b1;
                  if (i_tlast) pkt_done = 1'b1;
                  else         state_next = S_DRAIN;
               end else if (i_tlast) begin
                  pkt_done = 1'b1;
                  len_err  = (hdr_exp != 14'd1);
               end else if (hdr_exp == 14'd1) begin
                  // header alone already satisfies the length; more beats follow
                  len_err    = 1'b1;
                  state_next = S_DRAIN;
               end else begin
                  state_next = S_BODY;
               end
            end
            S_BODY: begin
               beat_cnt_next = beat_inc;
               if (i_tlast) begin
                  pkt_done   = 1'b1;
                  len_err    = (beat_inc != exp_beats);
                  state_next = S_HEAD;
               end else if (beat_inc == exp_beats) begin
                  len_err    = 1'b1;
                  state_next = S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (i_tlast) begin
                  pkt_done   = 1'b1;
                  state_next = S_HEAD;
               end
            end
            default: state_next = S_HEAD;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         first_pkt   <= 1'b1;
         prev_seq    <= 12'd0;
         last_seqnum <= 12'd0;
         last_len    <= 16'd0;
      end else begin
         if (hdr_seen) begin
            last_seqnum <= hdr_seq;
            last_len    <= hdr_len;
            prev_seq    <= hdr_seq;
            first_pkt   <= 1'b0;
         end
         if (clear_stb)
            first_pkt <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear_stb) begin
         pkt_count     <= 32'd0;
         seq_err_count <= 32'd0;
         len_err_count <= 32'd0;
         sid_err_count <= 32'd0;
      end else begin
         if (pkt_done) pkt_count     <= sat_inc(pkt_count);
         if (seq_err)  seq_err_count <= sat_inc(seq_err_count);
         if (len_err)  len_err_count <= sat_inc(len_err_count);
         if (sid_err)  sid_err_count <= sat_inc(sid_err_count);
      end
   end

endmodule

// File: tb/tb_chdr_pkt_checker.sv
module tb_chdr_pkt_checker;

   logic        clk = 1'b0;
   logic        reset;
   logic        set_stb;
   logic [7:0]  set_addr;
   logic [31:0] set_data;
   logic [63:0] i_tdata;
   logic        i_tlast;
   logic        i_tvalid;
   logic        i_tready;
   logic [31:0] pkt_count, seq_err_count, len_err_count, sid_err_count;
   logic [11:0] last_seqnum;
   logic [15:0] last_len;

   always #5 clk = ~clk;

   chdr_pkt_checker dut (
      .clk(clk), .reset(reset),
      .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .pkt_count(pkt_count), .seq_err_count(seq_err_count),
      .len_err_count(len_err_count), .sid_err_count(sid_err_count),
      .last_seqnum(last_seqnum), .last_len(last_len)
   );

   typedef struct {
      logic [31:0] pkt, seq_e, len_e, sid_e;
      logic [11:0] lseq;
      logic [15:0] llen;
   } snap_t;

   snap_t exp_q[$];
   int errors = 0;
   int checks = 0;

   // Packet-level reference model
   int          m_pkt, m_seq_e, m_len_e, m_sid_e;
   bit          m_en, m_sid_en, m_first;
   logic [31:0] m_exp_sid;
   int          m_prev;
   logic [11:0] m_lseq;
   logic [15:0] m_llen;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic snap_t cur_snap();
      snap_t s;
      s.pkt = m_pkt; s.seq_e = m_seq_e; s.len_e = m_len_e; s.sid_e = m_sid_e;
      s.lseq = m_lseq; s.llen = m_llen;
      return s;
   endfunction

   task automatic model_reset();
      m_pkt = 0; m_seq_e = 0; m_len_e = 0; m_sid_e = 0;
      m_en = 0; m_sid_en = 0; m_first = 1; m_exp_sid = 0; m_prev = 0;
      m_lseq = 0; m_llen = 0;
   endtask

   task automatic model_clear();
      m_pkt = 0; m_seq_e = 0; m_len_e = 0; m_sid_e = 0; m_first = 1;
   endtask

   task automatic model_pkt(input int seq, input int len, input bit ht,
                            input logic [31:0] sid, input int nb);
      int  expb;
      bit  short_len;
      if (!m_en) return;
      m_pkt++;
      if (!m_first && seq != (m_prev + 1) % 4096) m_seq_e++;
      m_prev  = seq;
      m_first = 0;
      if (m_sid_en && sid != m_exp_sid) m_sid_e++;
      expb      = (len + 7) / 8;
      short_len = (len < 8) || (ht && len < 16);
      if (short_len || nb != expb) m_len_e++;
      m_lseq = seq[11:0];
      m_llen = len[15:0];
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      @(negedge clk);
      set_stb = 1; set_addr = addr; set_data = data;
      case (addr)
         8'd0: begin m_en = data[0]; m_sid_en = data[1]; end
         8'd1: m_exp_sid = data;
         8'd2: model_clear();
         default: ;
      endcase
      @(negedge clk);
      set_stb = 0;
   endtask

   task automatic send_pkt(input int seq, input int len, input bit ht,
                           input logic [31:0] sid, input int nb, input bit clr);
      logic [63:0] h;
      for (int b = 0; b < nb; b++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            i_tvalid = 0; i_tlast = 0;
         end
         @(negedge clk);
         h = {$urandom, $urandom};
         if (b == 0) begin
            h[61]    = ht;
            h[59:48] = seq[11:0];
            h[47:32] = len[15:0];
            h[31:0]  = sid;
         end
         i_tdata  = h;
         i_tvalid = 1;
         i_tlast  = (b == nb - 1);
         if (b == nb - 1) begin
            model_pkt(seq, len, ht, sid, nb);
            if (clr) begin
               set_stb = 1; set_addr = 8'd2; set_data = $urandom;
               model_clear();
            end
            exp_q.push_back(cur_snap());
         end
      end
      @(negedge clk);
      i_tvalid = 0; i_tlast = 0; set_stb = 0;
   endtask

   // Scoreboard monitor: every packet end yields one expected snapshot.
   always @(posedge clk) begin
      if (i_tvalid && i_tready && i_tlast) begin
         #1;
         if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard: packet end seen with empty expectation queue at %0t", $time);
         end else begin
            snap_t s;
            s = exp_q.pop_front();
            check("pkt_count",     pkt_count,     s.pkt);
            check("seq_err_count", seq_err_count, s.seq_e);
            check("len_err_count", len_err_count, s.len_e);
            check("sid_err_count", sid_err_count, s.sid_e);
            check("last_seqnum",   {20'd0, last_seqnum}, {20'd0, s.lseq});
            check("last_len",      {16'd0, last_len},    {16'd0, s.llen});
         end
      end
   end

   always @(negedge clk) check("i_tready", {31'd0, i_tready}, {31'd0, ~reset});

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int seq, len, nb, expb;
      bit ht;
      logic [31:0] sid;

      reset = 1; set_stb = 0; set_addr = 0; set_data = 0;
      i_tdata = 0; i_tlast = 0; i_tvalid = 0;
      model_reset();
      repeat (3) @(negedge clk);
      reset = 0;
      @(negedge clk);
      check("reset pkt_count", pkt_count, 0);
      check("reset seq_err",   seq_err_count, 0);
      check("reset len_err",   len_err_count, 0);
      check("reset sid_err",   sid_err_count, 0);
      check("reset last_seqnum", {20'd0, last_seqnum}, 0);
      check("reset last_len",    {16'd0, last_len}, 0);

      // Basic: four in-order 3-beat packets
      wr(8'd0, 32'd1);
      for (int i = 0; i < 4; i++) send_pkt(i, 24, 0, 32'h0, 3, 0);
      check("plan pkt_count=4", pkt_count, 4);
      check("plan last_seqnum=3", {20'd0, last_seqnum}, 3);
      check("plan last_len=24", {16'd0, last_len}, 24);

      // Sequence wrap is legal, gap is not
      wr(8'd2, 32'd0);
      send_pkt(4094, 24, 0, 0, 3, 0);
      send_pkt(4095, 24, 0, 0, 3, 0);
      send_pkt(0,    24, 0, 0, 3, 0);
      send_pkt(2,    24, 0, 0, 3, 0);
      check("plan seq_err=1", seq_err_count, 1);

      // Length errors: early tlast, then overlong packet drained
      wr(8'd2, 32'd0);
      send_pkt(10, 32, 0, 0, 2, 0);
      send_pkt(11, 16, 0, 0, 5, 0);
      send_pkt(12, 24, 0, 0, 3, 0);
      check("plan len_err=2", len_err_count, 2);
      check("plan last_len after drain", {16'd0, last_len}, 24);
      // Short lengths: len<8, and len<16 with timestamp
      send_pkt(13, 4,  0, 0, 1, 0);
      send_pkt(14, 12, 1, 0, 2, 0);
      send_pkt(15, 16, 1, 0, 2, 0);
      check("short len_err=4", len_err_count, 4);

      // SID checking
      wr(8'd2, 32'd0);
      wr(8'd1, 32'h0001_0002);
      wr(8'd0, 32'd3);
      send_pkt(20, 24, 0, 32'h0001_0002, 3, 0);
      send_pkt(21, 24, 0, 32'h0003_0004, 3, 0);
      check("plan sid_err=1", sid_err_count, 1);
      wr(8'd0, 32'd1);
      send_pkt(22, 24, 0, 32'h0001_0002, 3, 0);
      send_pkt(23, 24, 0, 32'h0003_0004, 3, 0);
      check("plan sid_err unchanged", sid_err_count, 1);

      // Clear coincident with tlast, then arbitrary seq is not an error
      send_pkt(24, 24, 0, 0, 3, 1);
      send_pkt(999, 24, 0, 0, 3, 0);
      check("post-clear seq_err", seq_err_count, 0);
      check("post-clear pkt_count", pkt_count, 1);

      // Disabled: traffic discarded, counters frozen
      wr(8'd0, 32'd0);
      for (int i = 0; i < 3; i++) send_pkt(500 + 7 * i, 40, 0, 32'hdead, 2, 0);
      check("disabled pkt_count", pkt_count, 1);
      wr(8'd0, 32'd1);

      // Reset in the middle of a packet body
      @(negedge clk);
      i_tdata = 64'h0;
      i_tdata[59:48] = 12'd50; i_tdata[47:32] = 16'd32;
      i_tvalid = 1; i_tlast = 0;
      @(negedge clk);
      i_tdata = {$urandom, $urandom};
      @(negedge clk);
      i_tvalid = 0;
      reset = 1;
      @(negedge clk);
      reset = 0;
      model_reset();
      wr(8'd0, 32'd1);
      send_pkt(77, 24, 0, 0, 3, 0);
      check("post-reset pkt_count=1", pkt_count, 1);
      check("post-reset len_err=0", len_err_count, 0);

      // Randomized traffic against the packet-level model
      seq = 100;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 4) == 0) seq = $urandom_range(0, 4095);
         else seq = (seq + 1) % 4096;
         len  = $urandom_range(0, 80);
         ht   = $urandom_range(0, 1);
         expb = (len + 7) / 8;
         if (expb > 0 && $urandom_range(0, 1) == 1) nb = expb;
         else nb = $urandom_range(1, 12);
         sid = ($urandom_range(0, 1) == 1) ? 32'h0001_0002 : $urandom;
         if ($urandom_range(0, 19) == 0)
            wr(8'd0, {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0)});
         send_pkt(seq, len, ht, sid, nb, $urandom_range(0, 15) == 0);
      end

      repeat (4) @(negedge clk);
      check("scoreboard drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
